// File: rtl/sram_ctrl_pkg.sv
// Shared types and constants for the asynchronous SRAM controller.
package sram_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    R_ACCESS,
    W_SETUP,
    W_PULSE,
    W_HOLD,
    DONE
  } sram_state_t;

  localparam int   SRAM_ADDR_W = 20;
  localparam int   SRAM_DATA_W = 16;
  localparam logic STROBE_OFF  = 1'b1;

endpackage

// File: rtl/sram_controller.sv
// Turns single-cycle CPU read/write requests into timed bus cycles for an
// asynchronous 16-bit SRAM; every pin strobe is driven straight from a flop.
module sram_controller
  import sram_ctrl_pkg::*;
#(
  parameter int unsigned WaitCycles = 2,
  parameter int unsigned CntWidth   = $clog2(WaitCycles + 1)
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   Req,
  input  logic                   RW,
  input  logic [1:0]             ByteEn,
  input  logic [SRAM_ADDR_W-1:0] Addr,
  input  logic [SRAM_DATA_W-1:0] WData,
  output logic                   Ready,
  output logic                   Done,
  output logic [SRAM_DATA_W-1:0] RData,
  output logic                   CE,
  output logic                   OE,
  output logic                   WE,
  output logic                   LB,
  output logic                   UB,
  output logic [SRAM_ADDR_W-1:0] ADDR,
  inout  logic [SRAM_DATA_W-1:0] DQ
);

  sram_state_t            r_state, w_next;
  logic [CntWidth-1:0]    r_cnt, w_cnt_next;
  logic [SRAM_ADDR_W-1:0] r_addr;
  logic [SRAM_DATA_W-1:0] r_wdata, r_rdata, w_rd_masked;
  logic [1:0]             r_be, w_be;
  logic                   r_ready, r_done, r_ce, r_oe, r_we, r_lb, r_ub, r_drive;
  logic                   w_accept, w_last, w_active;

  assign w_accept    = (r_state == IDLE) && Req;
  assign w_last      = (r_cnt == '0);
  assign w_be        = w_accept ? ByteEn : r_be;
  assign w_active    = !(w_next == IDLE || w_next == DONE);
  assign w_rd_masked = {r_be[1] ? DQ[15:8] : 8'h00, r_be[0] ? DQ[7:0] : 8'h00};

  always_comb begin
    w_next     = r_state;
    w_cnt_next = r_cnt;
    unique case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_next = RW ? W_SETUP : R_ACCESS;
          if (!RW) w_cnt_next = CntWidth'(WaitCycles - 1);
        end
      end
      R_ACCESS: begin
        if (w_last) w_next = DONE;
        else        w_cnt_next = r_cnt - 1'b1;
      end
      W_SETUP: begin
        w_next     = W_PULSE;
        w_cnt_next = CntWidth'(WaitCycles - 1);
      end
      W_PULSE: begin
        if (w_last) w_next = W_HOLD;
        else        w_cnt_next = r_cnt - 1'b1;
      end
      W_HOLD:  w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Pin flops are loaded from the next state so they line up with r_state
  // while still being pure register outputs.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_be    <= '0;
      r_rdata <= '0;
      r_ready <= 1'b1;
      r_done  <= 1'b0;
      r_ce    <= STROBE_OFF;
      r_oe    <= STROBE_OFF;
      r_we    <= STROBE_OFF;
      r_lb    <= STROBE_OFF;
      r_ub    <= STROBE_OFF;
      r_drive <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
      if (w_accept) begin
        r_addr  <= Addr;
        r_wdata <= WData;
        r_be    <= ByteEn;
      end
      if (r_state == R_ACCESS && w_last) r_rdata <= w_rd_masked;
      r_ready <= (w_next == IDLE);
      r_done  <= (w_next == DONE);
      r_ce    <= w_active ? 1'b0 : STROBE_OFF;
      r_oe    <= (w_next == R_ACCESS) ? 1'b0 : STROBE_OFF;
      r_we    <= (w_next == W_PULSE) ? 1'b0 : STROBE_OFF;
      r_lb    <= w_active ? !w_be[0] : STROBE_OFF;
      r_ub    <= w_active ? !w_be[1] : STROBE_OFF;
      r_drive <= (w_next == W_SETUP) || (w_next == W_PULSE) || (w_next == W_HOLD);
    end
  end

  assign DQ    = r_drive ? r_wdata : 'z;
  assign Ready = r_ready;
  assign Done  = r_done;
  assign RData = r_rdata;
  assign CE    = r_ce;
  assign OE    = r_oe;
  assign WE    = r_we;
  assign LB    = r_lb;
  assign UB    = r_ub;
  assign ADDR  = r_addr;

endmodule

// File: tb/tb_sram_controller.sv
// Scoreboard bench for sram_controller against a behavioural async SRAM.
module tb_sram_controller;

  localparam int unsigned W = 2;

  logic        Clk = 1'b0, Reset = 1'b1, Req = 1'b0, RW = 1'b0;
  logic [1:0]  ByteEn = '0;
  logic [19:0] Addr = '0;
  logic [15:0] WData = '0;
  logic        Ready, Done, CE, OE, WE, LB, UB;
  logic [15:0] RData;
  logic [19:0] ADDR;
  wire  [15:0] DQ;

  sram_controller #(.WaitCycles(W)) dut (
    .Clk(Clk), .Reset(Reset), .Req(Req), .RW(RW), .ByteEn(ByteEn), .Addr(Addr),
    .WData(WData), .Ready(Ready), .Done(Done), .RData(RData), .CE(CE), .OE(OE),
    .WE(WE), .LB(LB), .UB(UB), .ADDR(ADDR), .DQ(DQ)
  );

  always #5 Clk = ~Clk;

  // Behavioural SRAM: drives on CE&OE low, writes selected bytes on WE rise.
  logic [15:0] mem [0:255] = '{default: '0};
  logic [15:0] sh  [0:255] = '{default: '0};
  logic        tb_drv = 1'b0;
  logic [15:0] tb_probe = '0;
  logic        sram_oe;
  logic [15:0] sram_q;
  assign sram_oe = !CE && !OE && WE;
  assign sram_q  = mem[ADDR[7:0]];
  assign DQ = tb_drv ? tb_probe : (sram_oe ? sram_q : 16'hzzzz);

  always @(posedge WE) begin
    if (Reset && !CE) begin
      if (!LB) mem[ADDR[7:0]][7:0]  = DQ[7:0];
      if (!UB) mem[ADDR[7:0]][15:8] = DQ[15:8];
    end
  end

  int checks = 0, failures = 0;
  int unsigned cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        rw;
    logic [15:0] exp;
    int unsigned acc;
  } exp_t;
  exp_t sbq[$];

  logic [19:0] cur_addr = '0;
  logic [15:0] cur_wdata = '0;
  logic [1:0]  cur_be = '0;

  // Monitor: bus rules every cycle, scoreboard pop on each Done.
  exp_t        mon_e;
  int unsigned we_cnt = 0, rdy_cnt = 0;
  int unsigned done_cyc[$], rdy_gap[$];
  logic        prev_done = 1'b0;
  always @(negedge Clk) begin
    if (!Reset) begin
      we_cnt = 0; rdy_cnt = 0; prev_done = 1'b0;
    end else begin
      check("oe_we_both_low", 32'(!OE && !WE), 0);
      if (prev_done) check("ready_after_done", Ready, 1);
      prev_done = Done;
      if (!WE) we_cnt++;
      if (Ready) rdy_cnt++;
      if (!CE) begin
        check("addr_stable", ADDR, cur_addr);
        check("lb", LB, !cur_be[0]);
        check("ub", UB, !cur_be[1]);
        if (!OE) check("dq_read_contention", DQ, sram_q);
        else     check("dq_write_data", DQ, cur_wdata);
      end
      if (Done) begin
        check("done_expected", 32'(sbq.size() != 0), 1);
        if (sbq.size() != 0) begin
          mon_e = sbq.pop_front();
          check("latency", cyc - mon_e.acc + 1, mon_e.rw ? W + 3 : W + 1);
          if (mon_e.rw) check("we_low_cycles", we_cnt, W);
          else          check("rdata", RData, mon_e.exp);
        end
        done_cyc.push_back(cyc);
        rdy_gap.push_back(rdy_cnt);
        we_cnt = 0; rdy_cnt = 0;
      end
    end
  end

  // Called at a negedge; leaves Req high so a following call is back-to-back.
  task automatic issue(input logic rw, input logic [1:0] be, input logic [19:0] a,
                       input logic [15:0] d, input logic [15:0] exp);
    int unsigned n = 0;
    Req = 1'b1; RW = rw; ByteEn = be; Addr = a; WData = d;
    while (!Ready && n < 50) begin @(negedge Clk); n++; end
    if (!Ready) begin
      check("ready_timeout", Ready, 1);
      return;
    end
    @(posedge Clk); #1;
    cur_addr = a; cur_wdata = d; cur_be = be;
    sbq.push_back('{rw, exp, cyc});
    @(negedge Clk);
  endtask

  task automatic drain();
    int unsigned n = 0;
    do begin @(negedge Clk); #1; n++; end
    while ((sbq.size() != 0 || !Ready) && n < 100);
    check("drain_idle", 32'(sbq.size() == 0 && Ready), 1);
    @(negedge Clk);
  endtask

  task automatic single(input logic rw, input logic [1:0] be, input logic [19:0] a,
                        input logic [15:0] d, input logic [15:0] exp);
    issue(rw, be, a, d, exp);
    Req = 1'b0;
    drain();
  endtask

  task automatic check_idle_pins(input string tag);
    check({tag, "_ce"}, CE, 1);
    check({tag, "_oe"}, OE, 1);
    check({tag, "_we"}, WE, 1);
    check({tag, "_lb"}, LB, 1);
    check({tag, "_ub"}, UB, 1);
    check({tag, "_ready"}, Ready, 1);
    check({tag, "_done"}, Done, 0);
    tb_probe = 16'h1234; tb_drv = 1'b1; #1;
    check({tag, "_dq_released"}, DQ, 16'h1234);
    tb_drv = 1'b0;
  endtask

  initial begin
    logic        rw;
    logic [1:0]  be;
    logic [7:0]  ai;
    logic [15:0] d, e;
    int unsigned n;

    #1 Reset = 1'b0;
    #2;
    check_idle_pins("reset");
    check("reset_rdata", RData, 0);
    check("reset_addr", ADDR, 0);
    @(negedge Clk); Reset = 1'b1;
    @(negedge Clk);

    // Word write/read, byte write, masked reads, ByteEn=00 boundaries.
    single(1'b1, 2'b11, 20'h00003, 16'hBEEF, 16'h0000);
    single(1'b0, 2'b11, 20'h00003, 16'h0000, 16'hBEEF);
    single(1'b1, 2'b01, 20'h00003, 16'h0012, 16'h0000);
    single(1'b0, 2'b11, 20'h00003, 16'h0000, 16'hBE12);
    single(1'b0, 2'b10, 20'h00003, 16'h0000, 16'hBE00);
    single(1'b0, 2'b00, 20'h00003, 16'h0000, 16'h0000);
    single(1'b1, 2'b00, 20'h00003, 16'h5555, 16'h0000);
    single(1'b0, 2'b11, 20'h00003, 16'h0000, 16'hBE12);

    // Back-to-back reads with Req held high.
    single(1'b1, 2'b11, 20'h0003B, 16'h1111, 16'h0000);
    single(1'b1, 2'b11, 20'h0003C, 16'h2222, 16'h0000);
    single(1'b1, 2'b11, 20'h0003D, 16'h3333, 16'h0000);
    issue(1'b0, 2'b11, 20'h0003B, 16'h0000, 16'h1111);
    issue(1'b0, 2'b11, 20'h0003C, 16'h0000, 16'h2222);
    issue(1'b0, 2'b11, 20'h0003D, 16'h0000, 16'h3333);
    Req = 1'b0;
    drain();
    n = done_cyc.size();
    check("b2b_spacing_1", done_cyc[n-2] - done_cyc[n-3], 4);
    check("b2b_spacing_2", done_cyc[n-1] - done_cyc[n-2], 4);
    check("b2b_ready_gap_1", rdy_gap[n-2], 1);
    check("b2b_ready_gap_2", rdy_gap[n-1], 1);

    // Reset while WE is low: strobes and DQ release immediately, no Done.
    issue(1'b1, 2'b11, 20'h00005, 16'hAAAA, 16'h0000);
    Req = 1'b0;
    @(negedge Clk);
    check("pulse_we_low", WE, 0);
    #2 Reset = 1'b0;
    #1;
    check_idle_pins("abort_pulse");
    sbq.delete();
    repeat (2) @(negedge Clk);
    Reset = 1'b1;
    repeat (4) @(negedge Clk);
    check("abort_pulse_ready", Ready, 1);

    // Reset before WE falls: the memory word must stay untouched.
    issue(1'b1, 2'b11, 20'h00010, 16'hFFFF, 16'h0000);
    Req = 1'b0;
    check("setup_we_high", WE, 1);
    #2 Reset = 1'b0;
    #1;
    check_idle_pins("abort_setup");
    sbq.delete();
    repeat (2) @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    single(1'b0, 2'b11, 20'h00010, 16'h0000, 16'h0000);

    // Random mix against the shadow memory, back-to-back.
    for (int i = 0; i < 200; i++) begin
      rw = 1'($urandom_range(0, 1));
      be = 2'($urandom_range(0, 3));
      ai = 8'h80 + 8'($urandom_range(0, 15));
      d  = 16'($urandom);
      e  = {be[1] ? sh[ai][15:8] : 8'h00, be[0] ? sh[ai][7:0] : 8'h00};
      if (rw) begin
        if (be[0]) sh[ai][7:0]  = d[7:0];
        if (be[1]) sh[ai][15:8] = d[15:8];
      end
      issue(rw, be, {12'h000, ai}, d, rw ? 16'h0000 : e);
    end
    Req = 1'b0;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #300000;
    failures++;
    $display("FAIL watchdog expired at t=%0t", $time);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sram_controller.md
Name: sram_controller

Overview:
- Initiator-side controller for the board's asynchronous 16-bit SRAM (active-low CE/OE/WE/LB/UB, 20-bit address, shared bidirectional DQ).
- Sits between the CPU memory stage (MAR/MDR request interface) and the SRAM pins.
- Turns single-cycle read/write requests into timed SRAM bus cycles with registered, glitch-free strobes.
- Returns read data with a one-cycle Done pulse.

Parameters:
- WaitCycles, 2, cycles the OE (read) or WE (write) strobe stays asserted. Legal range 1..15.
- CntWidth, $clog2(WaitCycles+1), width of the internal wait counter.

Ports:
- Clk  in  1  system clock. All state changes on the rising edge.
- Reset  in  1  asynchronous, active-low reset. Asserting it forces reset state immediately; it is released synchronously in use.
- Req  in  1  request strobe. Sampled only while Ready=1.
- RW  in  1  request type: 1 = write, 0 = read.
- ByteEn  in  2  byte enables: bit1 = upper byte, bit0 = lower byte.
- Addr  in  20  word address.
- WData  in  16  write data.
- Ready  out  1  controller idle; can accept a request.
- Done  out  1  one-cycle pulse when an access completes.
- RData  out  16  read data. Held until the next read completes.
- CE  out  1  SRAM chip enable, active-low.
- OE  out  1  SRAM output enable, active-low.
- WE  out  1  SRAM write enable, active-low.
- LB  out  1  SRAM lower-byte select, active-low.
- UB  out  1  SRAM upper-byte select, active-low.
- ADDR  out  20  SRAM address.
- DQ  inout  16  SRAM data bus. Driven only in write states; high-Z otherwise.

Behaviour:

Reset values (while Reset=0):
- State IDLE, Ready=1, Done=0, RData=0.
- CE=OE=WE=LB=UB=1, ADDR=0, DQ high-Z.
- Reset mid-access aborts the access at once: strobes return high, the DQ driver is released, and no Done is issued.

Request capture:
- Req=1 with Ready=1 at a rising edge latches Addr, WData, ByteEn and RW into internal registers.
- Ready drops on the next cycle.
- Inputs are ignored while Ready=0. Req held high re-issues the request when Ready returns.

Register and strobe rules:
- All SRAM pin outputs come from registers. No combinational path from Req to the pins.
- ADDR, LB and UB are stable for the whole access.
- LB=~ByteEn[0] and UB=~ByteEn[1] during an access; both are 1 in IDLE.

States:
- IDLE: Ready=1, all strobes high. Accept -> R_ACCESS or W_SETUP.
- R_ACCESS: CE=0, OE=0, WE=1, DQ high-Z; lasts WaitCycles cycles.
  - On the last cycle's edge, RData captures DQ, with disabled bytes forced to 0x00.
  - Next state: DONE.
- W_SETUP: 1 cycle. CE=0, OE=1, WE=1, DQ driven with the latched WData. Next: W_PULSE.
- W_PULSE: WaitCycles cycles. WE=0, DQ still driven. Next: W_HOLD.
- W_HOLD: 1 cycle. WE=1, CE=0, DQ still driven; gives data hold after WE rises. Next: DONE.
- DONE: 1 cycle. Done=1, CE=1, OE=1, DQ high-Z. Next: IDLE.

Invariants:
- OE and WE are never both low.
- DQ is never driven while OE=0.

Latency, counted from the accept edge:
- Read: Done is high in cycle WaitCycles+1.
- Write: Done is high in cycle WaitCycles+3.
- Back-to-back: the next request can be accepted in the cycle after Done (that cycle is IDLE).

Boundary cases:
- ByteEn=00: the access runs normally with LB=UB=1 (no SRAM effect). Done still pulses; a read returns 0x0000.
- The wait counter loads WaitCycles-1 on entry to R_ACCESS or W_PULSE and counts down to 0. It never wraps.
- The address is passed through unchanged; range checking belongs to the SRAM or decode logic.

Decomposition:
- Package sram_ctrl_pkg holds:
  - state enum sram_state_t: IDLE, R_ACCESS, W_SETUP, W_PULSE, W_HOLD, DONE.
  - constants SRAM_ADDR_W=20, SRAM_DATA_W=16, STROBE_OFF=1'b1.
- No sub-module. The wait counter, request registers, tristate driver (DQ = drive ? wdata : 'z) and FSM form one module.

Test Plan:
- Word write then read: write Addr=0x00003, WData=0xBEEF, ByteEn=11, then read Addr=0x00003.
  - Write Done at cycle 5 (WaitCycles=2).
  - WE low for exactly 2 cycles, with DQ=0xBEEF stable from W_SETUP through W_HOLD.
  - Read Done at cycle 3 with RData=0xBEEF.
- Byte write: write Addr=3, WData=0x0012, ByteEn=01.
  - LB=0, UB=1 during the access.
  - A full-word read then returns RData=0xBE12.
  - A read with ByteEn=10 returns 0xBE00.
- Back-to-back requests: hold Req=1, RW=0 for Addr 0x3B, 0x3C, 0x3D.
  - Three Done pulses spaced 4 cycles apart.
  - Ready=1 for exactly one cycle between accesses.
  - OE and WE are never simultaneously 0.
- Reset mid-write: drop Reset during W_PULSE.
  - WE, CE, LB and UB are 1 and DQ is high-Z in the same time step, with no clock edge needed.
  - No Done pulse; Ready=1 after release.
  - A memory word initialised to 0x0000 reads 0x0000 if WE had not yet fallen.
- Bus contention check: random mix of 200 reads and writes with random ByteEn against a behavioural SRAM model.
  - Read data matches the scoreboard.
  - DQ is never driven by both sides; the bench flags X or contention on DQ.
